// File: rtl/otter_fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and IF/DE outputs.
// The fetch stage connects as master; memory, hazard unit and Decode connect as slave.
interface otter_fetch_stage_if #(
  parameter int IMEM_AW = 14
);
  logic               stall;
  logic               flush;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               trap_valid;
  logic [31:0]        trap_pc;
  logic               imem_rden;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_dout;
  logic [31:0]        de_pc;
  logic [31:0]        de_pc_plus4;
  logic [31:0]        de_ir;
  logic               de_valid;

  modport master (
    input  stall, flush, redirect_valid, redirect_pc, trap_valid, trap_pc, imem_dout,
    output imem_rden, imem_addr, de_pc, de_pc_plus4, de_ir, de_valid
  );

  modport slave (
    output stall, flush, redirect_valid, redirect_pc, trap_valid, trap_pc, imem_dout,
    input  imem_rden, imem_addr, de_pc, de_pc_plus4, de_ir, de_valid
  );
endinterface

// File: rtl/otter_fetch_stage.sv
// OTTER RV32I instruction fetch: owns the fetch PC, drives a 1-cycle synchronous
// instruction memory and holds the IF/DE register, with a skid word for stalls.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  parameter int          IMEM_AW      = 14
) (
  input  logic                 CLK,
  input  logic                 RESET,
  otter_fetch_stage_if.master  bus
);

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_HOLD,
    PC_REDIRECT,
    PC_TRAP
  } pc_sel_e;

  typedef enum logic [1:0] {
    DE_LOAD,
    DE_HOLD,
    DE_KILL
  } de_act_e;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] de_pc_q;
  logic [31:0] de_pc4_q;
  logic        de_valid_q;
  logic [31:0] ir_hold;
  logic        hold_vld;
  pc_sel_e     pc_sel;
  de_act_e     de_act;

  assign pc_plus4 = pc_q + 32'd4;

  // Trap outranks redirect, and either outranks stall for both the PC and IF/DE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    pc_sel = PC_SEQ;
    de_act = DE_LOAD;
    if (bus.trap_valid)          pc_sel = PC_TRAP;
    else if (bus.redirect_valid) pc_sel = PC_REDIRECT;
    else if (bus.stall)          pc_sel = PC_HOLD;

    if (bus.trap_valid || bus.redirect_valid || bus.flush) de_act = DE_KILL;
    else if (bus.stall)                                   de_act = DE_HOLD;
  end

  // Redirect targets are forced word-aligned as they are loaded.
  always_comb begin
    pc_d = pc_plus4;
    case (pc_sel)
      PC_TRAP:     pc_d = bus.trap_pc & ~32'h3;
      PC_REDIRECT: pc_d = bus.redirect_pc & ~32'h3;
      PC_HOLD:     pc_d = pc_q;
      default:     pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_d;
  end

  // While stalled the memory keeps returning the word at pc_q, so the word already
  // presented to Decode is parked in ir_hold on the first stalled edge only.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      de_pc_q    <= 32'h0;
      de_pc4_q   <= 32'h0;
      de_valid_q <= 1'b0;
      ir_hold    <= 32'h0;
      hold_vld   <= 1'b0;
    end else begin
      case (de_act)
        DE_KILL: begin
          de_valid_q <= 1'b0;
          hold_vld   <= 1'b0;
        end
        DE_HOLD: begin
          if (!hold_vld) begin
            ir_hold  <= bus.imem_dout;
            hold_vld <= 1'b1;
          end
        end
        default: begin
          de_pc_q    <= pc_q;
          de_pc4_q   <= pc_plus4;
          de_valid_q <= 1'b1;
          hold_vld   <= 1'b0;
        end
      endcase
    end
  end

  // Read enable drops with RESET itself so the memory sees it without waiting for an edge.
  assign bus.imem_rden   = ~RESET;
  assign bus.imem_addr   = pc_q[IMEM_AW+1:2];
  assign bus.de_pc       = de_pc_q;
  assign bus.de_pc_plus4 = de_pc4_q;
  assign bus.de_valid    = de_valid_q;

  always_comb begin
    bus.de_ir = bus.imem_dout;
    if (!de_valid_q)   bus.de_ir = NOP_INSTR;
    else if (hold_vld) bus.de_ir = ir_hold;
  end

endmodule
